aes_arbiter: RTL

Round-robin arbiter and sequencer that shares one `aes_encryption` core among `NUM_REQ` requesters. It accepts {plaintext, key} requests over per-requester valid/ready handshakes and drives the core's `init_in`/`data_in`/`key_in`. It captures `data_out` when `valid_out` arrives and returns the ciphertext to the granted requester over a valid/ready response channel. It sits between client blocks and the single AES core instance.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/aes_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES request arbiter slice.
//   aes_block_t             : one 128-bit AES block (plaintext, key or ciphertext)
//   aes_arb_state_t         : sequencer states of aes_arbiter
//   AES_ARB_DEFAULT_TIMEOUT : default watchdog limit (WAIT cycles) used when
//                             aes_arbiter is built with AES_ARB_TIMEOUT_EN
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SETTLE,
        WAIT,
        RESP
    } aes_arb_state_t;

    localparam int AES_ARB_DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant. Searches the valid vector starting at
// index ptr and moving upward with wrap-around; the first valid index found
// receives a one-hot grant. The pointer itself is owned by the caller.
// Ports:
//   valid [N-1:0]     in  : request valid vector
//   ptr   [PTR_W-1:0] in  : highest-priority index for this search (< N)
//   grant [N-1:0]     out : one-hot grant, or zero when nothing is valid
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // Walk all N positions in priority order starting at ptr; only the first
    // valid position found is granted, later ones are masked by 'found'.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_arbiter.sv
// ---------------------------------------------------------------------------
// aes_arbiter
// Shares a single AES encryption core among NUM_REQ requesters. A request
// {plaintext, key} is accepted round-robin in IDLE, the core is started with a
// one-cycle init pulse, the ciphertext is captured when the core reports done,
// and it is handed back to the granted requester over a valid/ready channel.
// Only one transaction is in flight at any time.
//
// Optional feature: define AES_ARB_TIMEOUT_EN to add a WAIT-state watchdog.
// After TIMEOUT_CYCLES WAIT cycles without aes_valid_in the response is
// returned with resp_err_out=1 and zero data. Undefined: resp_err_out is 0.
//
// Ports:
//   clk_in, rst_in        : clock (rising edge), async active-high reset
//   req_valid_in  [N]     : per-requester request valid
//   req_ready_out [N]     : request accepted (one-hot or zero, IDLE only)
//   req_data_in   [N*128] : plaintexts, requester i at [128*i +: 128]
//   req_key_in    [N*128] : keys, same packing
//   resp_valid_out[N]     : response valid to the granted requester
//   resp_ready_in [N]     : response ready per requester
//   resp_data_out [128]   : ciphertext (shared)
//   resp_err_out          : response is a timeout error
//   aes_init_out          : one-cycle start pulse to the core
//   aes_data_out  [128]   : plaintext to the core
//   aes_key_out   [128]   : key to the core
//   aes_data_in   [128]   : ciphertext from the core
//   aes_valid_in          : core done flag
// ---------------------------------------------------------------------------
module aes_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = AES_ARB_DEFAULT_TIMEOUT
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_REQ-1:0]     req_valid_in,
    output logic [NUM_REQ-1:0]     req_ready_out,
    input  logic [NUM_REQ*128-1:0] req_data_in,
    input  logic [NUM_REQ*128-1:0] req_key_in,
    output logic [NUM_REQ-1:0]     resp_valid_out,
    input  logic [NUM_REQ-1:0]     resp_ready_in,
    output logic [127:0]           resp_data_out,
    output logic                   resp_err_out,
    output logic                   aes_init_out,
    output logic [127:0]           aes_data_out,
    output logic [127:0]           aes_key_out,
    input  logic [127:0]           aes_data_in,
    input  logic                   aes_valid_in
);

    localparam int PTR_W = $clog2(NUM_REQ);

    aes_arb_state_t     state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   sel_idx;
    aes_block_t         sel_data;
    aes_block_t         sel_key;
    logic               any_req;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [CNT_W-1:0] wait_cnt;
    logic             resp_err_q;
`endif

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .valid (req_valid_in),
        .ptr   (ptr),
        .grant (grant)
    );

    // Select the granted requester's plaintext, key and index. The grant is
    // one-hot so at most one iteration overrides the zero defaults.
    always_comb begin
        sel_data = '0;
        sel_key  = '0;
        sel_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data_in[128*i +: 128];
                sel_key  = req_key_in[128*i +: 128];
                sel_idx  = PTR_W'(i);
            end
        end
    end

    assign any_req = |grant;

    // The accept is combinational so a requester sees ready in the same cycle
    // its valid is granted. It is gated by reset so every output reads zero
    // while reset is held, even with requests pending.
    assign req_ready_out = (state == IDLE && !rst_in) ? grant : '0;

`ifdef AES_ARB_TIMEOUT_EN
    assign resp_err_out = resp_err_q;
`else
    assign resp_err_out = 1'b0;
`endif

    // Sequencer: IDLE accepts, START pulses the core, SETTLE skips the cycle
    // in which the core's done flag may still be high from the previous job,
    // WAIT captures the ciphertext (or times out), RESP holds the response
    // until the granted requester takes it. All core/response outputs are
    // registered here; a reset drops any transaction in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            ptr            <= '0;
            gnt_idx        <= '0;
            aes_init_out   <= 1'b0;
            aes_data_out   <= '0;
            aes_key_out    <= '0;
            resp_valid_out <= '0;
            resp_data_out  <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            wait_cnt       <= '0;
            resp_err_q     <= 1'b0;
`endif
        end else begin
            aes_init_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        aes_data_out <= sel_data;
                        aes_key_out  <= sel_key;
                        gnt_idx      <= sel_idx;
                        ptr          <= (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
                        aes_init_out <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    state <= SETTLE;
                end
                SETTLE: begin
`ifdef AES_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state    <= WAIT;
                end
                WAIT: begin
                    if (aes_valid_in) begin
                        resp_data_out  <= aes_data_in;
                        resp_valid_out <= NUM_REQ'(1) << gnt_idx;
`ifdef AES_ARB_TIMEOUT_EN
                        resp_err_q     <= 1'b0;
`endif
                        state          <= RESP;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_data_out  <= '0;
                        resp_err_q     <= 1'b1;
                        resp_valid_out <= NUM_REQ'(1) << gnt_idx;
                        state          <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (resp_ready_in[gnt_idx]) begin
                        resp_valid_out <= '0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
